// File: rtl/rv64_wb_sched_if.sv
// Bundle of the issue, write-back and register-file signals of the
// write-back scheduler. The master side is the pipeline around the scheduler.
// The slave side is the scheduler itself.
interface rv64_wb_sched_if #(
   parameter int XLEN          = 64,
   parameter int REG_ADDRWIDTH = 5,
   parameter int REG_NUM       = 32
);
   // issue stage
   logic                     iss_valid;
   logic [REG_ADDRWIDTH-1:0] iss_rs1_idx;
   logic [REG_ADDRWIDTH-1:0] iss_rs2_idx;
   logic                     iss_use_rs1;
   logic                     iss_use_rs2;
   logic [REG_ADDRWIDTH-1:0] iss_rd;
   logic                     iss_rd_wen;
   logic                     iss_ready;

   // execute-unit write-back
   logic                     exu_valid;
   logic [REG_ADDRWIDTH-1:0] exu_rd;
   logic [XLEN-1:0]          exu_data;
   logic                     exu_ready;

   // load/store-unit write-back
   logic                     lsu_valid;
   logic [REG_ADDRWIDTH-1:0] lsu_rd;
   logic [XLEN-1:0]          lsu_data;
   logic                     lsu_ready;

   // register-file write port
   logic                     rf_wen;
   logic [REG_ADDRWIDTH-1:0] rf_waddr;
   logic [XLEN-1:0]          rf_wdata;

   // bypass, scoreboard view and error flag
   logic                     fwd_rs1_hit;
   logic                     fwd_rs2_hit;
   logic [XLEN-1:0]          fwd_data;
   logic [REG_NUM-1:0]       busy_vec;
   logic                     sb_err;

   modport master (
      output iss_valid, iss_rs1_idx, iss_rs2_idx, iss_use_rs1, iss_use_rs2,
             iss_rd, iss_rd_wen,
      input  iss_ready,
      output exu_valid, exu_rd, exu_data,
      input  exu_ready,
      output lsu_valid, lsu_rd, lsu_data,
      input  lsu_ready,
      input  rf_wen, rf_waddr, rf_wdata,
      input  fwd_rs1_hit, fwd_rs2_hit, fwd_data, busy_vec, sb_err
   );

   modport slave (
      input  iss_valid, iss_rs1_idx, iss_rs2_idx, iss_use_rs1, iss_use_rs2,
             iss_rd, iss_rd_wen,
      output iss_ready,
      input  exu_valid, exu_rd, exu_data,
      output exu_ready,
      input  lsu_valid, lsu_rd, lsu_data,
      output lsu_ready,
      output rf_wen, rf_waddr, rf_wdata,
      output fwd_rs1_hit, fwd_rs2_hit, fwd_data, busy_vec, sb_err
   );
endinterface

// File: rtl/rv64_wb_sched.sv
// Write-back scheduler and scoreboard for the RV64 integer register file.
// The EXU and the LSU share one register-file write port. LSU has priority
// unless the EXU has been blocked STARVE_MAX cycles in a row. A 32-entry busy
// scoreboard stalls issue on RAW/WAW hazards. Same-cycle write data is
// forwarded to issue, because the register file returns the old value during
// a write.
module rv64_wb_sched #(
   parameter int XLEN          = 64,
   parameter int REG_ADDRWIDTH = 5,
   parameter int REG_NUM       = 32,
   parameter int STARVE_MAX    = 4
) (
   input  logic               clk,
   input  logic               rst,
   rv64_wb_sched_if.slave     bus
);

   // Sequential state
   logic [3:0]         starve_cnt_q, starve_cnt_d;
   logic [REG_NUM-1:0] busy_q,       busy_d;
   logic               sb_err_q,     sb_err_d;

   // Arbitration and write-port signals
   logic                     starve_hit;
   logic                     exu_grant;
   logic                     lsu_grant;
   logic                     wb_grant;
   logic                     wb_wen;
   logic [REG_ADDRWIDTH-1:0] wb_rd;
   logic [XLEN-1:0]          wb_data;

   // Issue-side signals
   logic rs1_hit;
   logic rs2_hit;
   logic rs1_haz;
   logic rs2_haz;
   logic waw_haz;
   logic iss_ready_int;
   logic iss_fire;

   assign starve_hit = (starve_cnt_q == 4'(STARVE_MAX));

   // Arbitrate between EXU and LSU and drive the shared write port
   always_comb begin
      // NOTE: every output of this block gets a value before any branch, so
      // no path can leave one unassigned and infer a latch.
      exu_grant = 1'b0;
      lsu_grant = 1'b0;
      wb_rd     = '0;
      wb_data   = '0;
      if (!rst) begin
         exu_grant = bus.exu_valid & (~bus.lsu_valid | starve_hit);
         lsu_grant = bus.lsu_valid & ~exu_grant;
      end
      if (exu_grant) begin
         wb_rd   = bus.exu_rd;
         wb_data = bus.exu_data;
      end else if (lsu_grant) begin
         wb_rd   = bus.lsu_rd;
         wb_data = bus.lsu_data;
      end
      wb_grant = exu_grant | lsu_grant;
      // x0 writes complete their handshake but never reach the register file
      wb_wen   = wb_grant & (wb_rd != '0);
   end

   // Forwarding and hazard detection for the instruction at issue
   always_comb begin
      rs1_hit = bus.iss_use_rs1 & wb_wen & (wb_rd == bus.iss_rs1_idx);
      rs2_hit = bus.iss_use_rs2 & wb_wen & (wb_rd == bus.iss_rs2_idx);
      rs1_haz = bus.iss_use_rs1 & busy_q[bus.iss_rs1_idx] & ~rs1_hit;
      rs2_haz = bus.iss_use_rs2 & busy_q[bus.iss_rs2_idx] & ~rs2_hit;
      // A pending rd that is written back this cycle is free at the edge
      waw_haz = bus.iss_rd_wen & busy_q[bus.iss_rd]
              & ~(wb_wen & (wb_rd == bus.iss_rd));
      iss_ready_int = ~rst & ~(rs1_haz | rs2_haz | waw_haz);
      iss_fire      = bus.iss_valid & iss_ready_int;
   end

   // Next-state for the starvation counter, scoreboard and error flag
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      busy_d       = busy_q;
      sb_err_d     = sb_err_q;

      if (!bus.exu_valid || exu_grant) begin
         starve_cnt_d = '0;
      end else if (!starve_hit) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end

      if (wb_wen) begin
         if (!busy_q[wb_rd]) begin
            sb_err_d = 1'b1;
         end
         busy_d[wb_rd] = 1'b0;
      end

      // Set after clear so a re-issue to the same rd keeps it busy
      if (iss_fire && bus.iss_rd_wen && (bus.iss_rd != '0)) begin
         busy_d[bus.iss_rd] = 1'b1;
      end

      busy_d[0] = 1'b0;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its d input from before the edge, whatever the block order.
      if (rst) begin
         starve_cnt_q <= '0;
         busy_q       <= '0;
         sb_err_q     <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         busy_q       <= busy_d;
         sb_err_q     <= sb_err_d;
      end
   end

   // Outputs are forced to zero while reset is held, including registered ones
   assign bus.iss_ready   = iss_ready_int;
   assign bus.exu_ready   = exu_grant;
   assign bus.lsu_ready   = lsu_grant;
   assign bus.rf_wen      = wb_wen;
   assign bus.rf_waddr    = wb_rd;
   assign bus.rf_wdata    = wb_data;
   assign bus.fwd_rs1_hit = rs1_hit;
   assign bus.fwd_rs2_hit = rs2_hit;
   assign bus.fwd_data    = wb_data;
   assign bus.busy_vec    = rst ? '0 : busy_q;
   assign bus.sb_err      = sb_err_q & ~rst;

endmodule

// File: tb/tb_rv64_wb_sched.sv
// Directed bench for rv64_wb_sched: arbitration, starvation override,
// scoreboard set/clear, forwarding, x0 handling, protocol error and reset.
module tb_rv64_wb_sched;

   localparam int XLEN = 64;
   localparam int RAW  = 5;
   localparam int RN   = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   rv64_wb_sched_if #(.XLEN(XLEN), .REG_ADDRWIDTH(RAW), .REG_NUM(RN)) bus ();

   rv64_wb_sched #(
      .XLEN(XLEN), .REG_ADDRWIDTH(RAW), .REG_NUM(RN), .STARVE_MAX(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.iss_valid   = 1'b0;
      bus.iss_rs1_idx = '0;
      bus.iss_rs2_idx = '0;
      bus.iss_use_rs1 = 1'b0;
      bus.iss_use_rs2 = 1'b0;
      bus.iss_rd      = '0;
      bus.iss_rd_wen  = 1'b0;
      bus.exu_valid   = 1'b0;
      bus.exu_rd      = '0;
      bus.exu_data    = '0;
      bus.lsu_valid   = 1'b0;
      bus.lsu_rd      = '0;
      bus.lsu_data    = '0;
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an issue that writes rd and uses no sources
   task automatic issue_rd(input logic [RAW-1:0] rd);
      bus.iss_valid  = 1'b1;
      bus.iss_rd     = rd;
      bus.iss_rd_wen = 1'b1;
   endtask

   // Both units valid on x0 for six cycles; EXU must win only on the fifth
   task automatic starve_run(input string tag);
      bus.exu_valid = 1'b1;
      bus.exu_rd    = '0;
      bus.exu_data  = 64'hE;
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = '0;
      bus.lsu_data  = 64'h1;
      for (int i = 1; i <= 6; i++) begin
         #1;
         check($sformatf("%s exu_ready c%0d", tag, i), 64'(bus.exu_ready),
               64'(i == 5));
         check($sformatf("%s lsu_ready c%0d", tag, i), 64'(bus.lsu_ready),
               64'(i != 5));
         tick();
      end
      idle();
   endtask

   initial begin
      // ---------------- reset hold: outputs zero despite active inputs
      idle();
      bus.exu_valid   = 1'b1;
      bus.exu_rd      = 5'd9;
      bus.exu_data    = 64'h77;
      bus.lsu_valid   = 1'b1;
      bus.lsu_rd      = 5'd9;
      bus.lsu_data    = 64'h88;
      bus.iss_valid   = 1'b1;
      bus.iss_use_rs1 = 1'b1;
      bus.iss_rs1_idx = 5'd9;
      #1;
      check("rst exu_ready", 64'(bus.exu_ready), 64'd0);
      check("rst lsu_ready", 64'(bus.lsu_ready), 64'd0);
      check("rst rf_wen",    64'(bus.rf_wen),    64'd0);
      check("rst rf_wdata",  bus.rf_wdata,       64'd0);
      check("rst iss_ready", 64'(bus.iss_ready), 64'd0);
      check("rst fwd_hit",   64'(bus.fwd_rs1_hit), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      idle();
      #1;
      check("post-rst busy_vec",  64'(bus.busy_vec),  64'd0);
      check("post-rst iss_ready", 64'(bus.iss_ready), 64'd1);
      check("post-rst sb_err",    64'(bus.sb_err),    64'd0);

      // ---------------- make rd 5 and rd 6 busy
      issue_rd(5'd5);
      #1;
      check("issue rd5 ready", 64'(bus.iss_ready), 64'd1);
      tick();
      issue_rd(5'd6);
      #1;
      check("busy after rd5", 64'(bus.busy_vec), 64'h20);
      tick();
      idle();
      #1;
      check("busy after rd6", 64'(bus.busy_vec), 64'h60);

      // ---------------- EXU/LSU collision
      bus.exu_valid = 1'b1;
      bus.exu_rd    = 5'd5;
      bus.exu_data  = 64'h55;
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 5'd6;
      bus.lsu_data  = 64'h66;
      #1;
      check("coll c0 lsu_ready", 64'(bus.lsu_ready), 64'd1);
      check("coll c0 exu_ready", 64'(bus.exu_ready), 64'd0);
      check("coll c0 rf_waddr",  64'(bus.rf_waddr),  64'd6);
      check("coll c0 rf_wdata",  bus.rf_wdata,       64'h66);
      check("coll c0 rf_wen",    64'(bus.rf_wen),    64'd1);
      tick();
      bus.lsu_valid = 1'b0;
      #1;
      check("coll c1 exu_ready", 64'(bus.exu_ready), 64'd1);
      check("coll c1 rf_waddr",  64'(bus.rf_waddr),  64'd5);
      check("coll c1 rf_wdata",  bus.rf_wdata,       64'h55);
      check("coll c1 busy_vec",  64'(bus.busy_vec),  64'h20);
      tick();
      idle();
      #1;
      check("coll busy cleared", 64'(bus.busy_vec), 64'd0);
      check("coll no sb_err",    64'(bus.sb_err),    64'd0);

      // ---------------- starvation override (x0 so scoreboard is untouched)
      starve_run("starve");
      #1;
      check("starve x0 no sb_err", 64'(bus.sb_err), 64'd0);

      // ---------------- RAW stall then forward
      issue_rd(5'd3);
      tick();
      idle();
      #1;
      check("raw busy[3] set", 64'(bus.busy_vec), 64'h8);
      bus.iss_valid   = 1'b1;
      bus.iss_use_rs1 = 1'b1;
      bus.iss_rs1_idx = 5'd3;
      #1;
      check("raw stall ready", 64'(bus.iss_ready),   64'd0);
      check("raw stall hit",   64'(bus.fwd_rs1_hit), 64'd0);
      tick();
      check("raw still stall", 64'(bus.iss_ready),   64'd0);
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 5'd3;
      bus.lsu_data  = 64'hDEAD;
      #1;
      check("raw fwd hit",   64'(bus.fwd_rs1_hit), 64'd1);
      check("raw fwd data",  bus.fwd_data,         64'hDEAD);
      check("raw fwd ready", 64'(bus.iss_ready),   64'd1);
      tick();
      idle();
      #1;
      check("raw busy[3] clear", 64'(bus.busy_vec), 64'd0);

      // ---------------- rs2 hazard and source-use gating
      issue_rd(5'd10);
      tick();
      idle();
      bus.iss_valid   = 1'b1;
      bus.iss_rs2_idx = 5'd10;
      #1;
      check("rs2 unused ready", 64'(bus.iss_ready), 64'd1);
      bus.iss_use_rs2 = 1'b1;
      #1;
      check("rs2 hazard ready", 64'(bus.iss_ready), 64'd0);
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 5'd10;
      bus.lsu_data  = 64'hA5;
      #1;
      check("rs2 fwd hit", 64'(bus.fwd_rs2_hit), 64'd1);
      tick();
      idle();

      // ---------------- WAW stall, bypass and set-beats-clear
      issue_rd(5'd8);
      tick();
      #1;
      check("waw stall ready", 64'(bus.iss_ready), 64'd0);
      bus.exu_valid = 1'b1;
      bus.exu_rd    = 5'd8;
      bus.exu_data  = 64'h8;
      #1;
      check("waw wb ready", 64'(bus.iss_ready), 64'd1);
      tick();
      idle();
      #1;
      check("waw set wins", 64'(bus.busy_vec), 64'h100);
      bus.exu_valid = 1'b1;
      bus.exu_rd    = 5'd8;
      tick();
      idle();
      #1;
      check("waw cleared",   64'(bus.busy_vec), 64'd0);
      check("waw no sb_err", 64'(bus.sb_err),   64'd0);

      // ---------------- x0 handling
      bus.exu_valid = 1'b1;
      bus.exu_rd    = 5'd0;
      bus.exu_data  = 64'h123;
      issue_rd(5'd0);
      #1;
      check("x0 exu_ready", 64'(bus.exu_ready), 64'd1);
      check("x0 rf_wen",    64'(bus.rf_wen),    64'd0);
      check("x0 iss_ready", 64'(bus.iss_ready), 64'd1);
      tick();
      idle();
      #1;
      check("x0 busy_vec", 64'(bus.busy_vec), 64'd0);
      check("x0 sb_err",   64'(bus.sb_err),   64'd0);

      // ---------------- protocol error: write-back to idle rd 7
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 5'd7;
      bus.lsu_data  = 64'h7;
      #1;
      check("err lsu_ready", 64'(bus.lsu_ready), 64'd1);
      check("err pre sb_err", 64'(bus.sb_err),   64'd0);
      tick();
      idle();
      #1;
      check("err sb_err set", 64'(bus.sb_err), 64'd1);
      tick();
      tick();
      check("err sb_err sticky", 64'(bus.sb_err), 64'd1);

      // ---------------- reset mid-flight
      issue_rd(5'd4);
      tick();
      issue_rd(5'd9);
      tick();
      idle();
      #1;
      check("mid busy 4,9", 64'(bus.busy_vec), 64'h210);
      bus.exu_valid = 1'b1;
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 5'd4;
      bus.lsu_data  = 64'h44;
      tick();
      bus.lsu_rd    = 5'd9;
      bus.lsu_data  = 64'h99;
      tick();
      bus.lsu_rd      = 5'd9;
      bus.iss_valid   = 1'b1;
      bus.iss_use_rs1 = 1'b1;
      bus.iss_rs1_idx = 5'd9;
      rst = 1'b1;
      #1;
      check("mid rst lsu_ready", 64'(bus.lsu_ready),   64'd0);
      check("mid rst exu_ready", 64'(bus.exu_ready),   64'd0);
      check("mid rst rf_waddr",  64'(bus.rf_waddr),    64'd0);
      check("mid rst fwd_hit",   64'(bus.fwd_rs1_hit), 64'd0);
      check("mid rst busy_vec",  64'(bus.busy_vec),    64'd0);
      check("mid rst sb_err",    64'(bus.sb_err),      64'd0);
      check("mid rst iss_ready", 64'(bus.iss_ready),   64'd0);
      tick();
      rst = 1'b0;
      idle();
      #1;
      check("after rst busy_vec", 64'(bus.busy_vec), 64'd0);
      check("after rst sb_err",   64'(bus.sb_err),   64'd0);
      // starve_cnt must restart from 0: EXU again waits four cycles
      starve_run("after rst starve");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
